cond_wait_unit: RTL and testbench

//  Multi-channel hardware equivalent of a blocking wait(cond). Each of NCH

---
 rtl/cond_wait_unit.sv | 132 +++++++++++++
 tb/tb_cond_wait_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_wait_unit.sv
// cond_wait_unit
//  Multi-channel, time-bounded wait(cond) event source. Each channel is armed
//  with a compare mode and lo/hi thresholds. From the edge after the arm edge it
//  samples the shared value bus every cycle. It pulses hit on the first sample
//  that satisfies its condition, and pulses timeout once the optional sample
//  budget is exhausted.
//
//  Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   value        observed value, sampled every posedge
//   arm_valid    per-channel arm request (accepted when arm_ready)
//   arm_ready    channel idle
//   arm_mode     3 bits/channel: EQ NE LT LE GT GE EXCL INCL
//   arm_lo/hi    thresholds per channel
//   arm_tmo      timeout in samples per channel, 0 = forever
//   cancel       abort an armed wait, no pulse
//   busy         channel armed
//   hit/timeout  one-cycle result pulses
//   hit_value    value at the last hit, per channel
//
//  state     | meaning
//  ST_IDLE   | channel free, arm_ready=1
//  ST_ARMED  | waiting on condition / timeout, busy=1
module cond_wait_unit #(
   parameter int WIDTH  = 32,
   parameter int NCH    = 4,
   parameter int TMO_W  = 16,
   parameter int SIGNED = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       value,
   input  logic [NCH-1:0]         arm_valid,
   output logic [NCH-1:0]         arm_ready,
   input  logic [3*NCH-1:0]       arm_mode,
   input  logic [WIDTH*NCH-1:0]   arm_lo,
   input  logic [WIDTH*NCH-1:0]   arm_hi,
   input  logic [TMO_W*NCH-1:0]   arm_tmo,
   input  logic [NCH-1:0]         cancel,
   output logic [NCH-1:0]         busy,
   output logic [NCH-1:0]         hit,
   output logic [NCH-1:0]         timeout,
   output logic [WIDTH*NCH-1:0]   hit_value
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;
   localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic SGN = (SIGNED != 0);

   // Operands are widened by one bit: the extra bit is the sign for signed
   // compares and zero for unsigned ones, so a single signed comparator
   // covers both parameterisations.
   logic signed [WIDTH:0] v_x;
   assign v_x = {SGN & value[WIDTH-1], value};

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [0:0]       state;
      logic [2:0]       mode;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] hv;
      logic [TMO_W-1:0] cnt;
      logic             hit_r;
      logic             tmo_r;
      logic             cond;
      logic signed [WIDTH:0] lo_x;
      logic signed [WIDTH:0] hi_x;

      always_comb begin
         lo_x = {SGN & lo[WIDTH-1], lo};
         hi_x = {SGN & hi[WIDTH-1], hi};
         cond = 1'b0;
         case (mode)
            3'd0: cond = (v_x == lo_x);
            3'd1: cond = (v_x != lo_x);
            3'd2: cond = (v_x <  lo_x);
            3'd3: cond = (v_x <= lo_x);
            3'd4: cond = (v_x >  lo_x);
            3'd5: cond = (v_x >= lo_x);
            3'd6: cond = (v_x >  lo_x) && (v_x <  hi_x);
            default: cond = (v_x >= lo_x) && (v_x <= hi_x);
         endcase
      end

      // cnt==0 while armed means no timeout; a loaded budget of N reaches the
      // terminal count of 1 on the Nth failing sample.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= ST_IDLE;
            mode  <= '0;
            lo    <= '0;
            hi    <= '0;
            hv    <= '0;
            cnt   <= '0;
            hit_r <= 1'b0;
            tmo_r <= 1'b0;
         end else begin
            hit_r <= 1'b0;
            tmo_r <= 1'b0;
            if (state == ST_IDLE) begin
               if (arm_valid[g]) begin
                  state <= ST_ARMED;
                  mode  <= arm_mode[3*g +: 3];
                  lo    <= arm_lo[WIDTH*g +: WIDTH];
                  hi    <= arm_hi[WIDTH*g +: WIDTH];
                  cnt   <= arm_tmo[TMO_W*g +: TMO_W];
               end
            end else if (cancel[g]) begin
               state <= ST_IDLE;
            end else if (cond) begin
               state <= ST_IDLE;
               hit_r <= 1'b1;
               hv    <= value;
            end else if (cnt == CNT_ONE) begin
               state <= ST_IDLE;
               tmo_r <= 1'b1;
               cnt   <= '0;
            end else if (cnt != '0) begin
               cnt <= cnt - CNT_ONE;
            end
         end
      end

      assign arm_ready[g]                = (state == ST_IDLE);
      assign busy[g]                     = (state == ST_ARMED);
      assign hit[g]                      = hit_r;
      assign timeout[g]                  = tmo_r;
      assign hit_value[WIDTH*g +: WIDTH] = hv;
   end

endmodule

// File: tb/tb_cond_wait_unit.sv
module tb_cond_wait_unit;
   localparam int W = 32;
   localparam int N = 4;
   localparam int T = 16;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  value;
   logic [N-1:0]  arm_valid;
   logic [N-1:0]  cancel;
   logic [3*N-1:0] arm_mode;
   logic [W*N-1:0] arm_lo;
   logic [W*N-1:0] arm_hi;
   logic [T*N-1:0] arm_tmo;

   logic [N-1:0]   rdy_s, busy_s, hit_s, tmo_s;
   logic [W*N-1:0] hv_s;
   logic [N-1:0]   rdy_u, busy_u, hit_u, tmo_u;
   logic [W*N-1:0] hv_u;

   logic [2:0]   a_mode[N];
   logic [W-1:0] a_lo[N];
   logic [W-1:0] a_hi[N];
   logic [T-1:0] a_tmo[N];

   int checks = 0;
   int errors = 0;

   // reference model, index 0 = signed instance, 1 = unsigned instance
   bit          m_armed[2][N];
   logic [2:0]  m_mode[2][N];
   longint      m_lo[2][N];
   longint      m_hi[2][N];
   int          m_left[2][N];
   bit          e_hit[2][N];
   bit          e_tmo[2][N];
   logic [W-1:0] e_hv[2][N];

   cond_wait_unit #(.WIDTH(W), .NCH(N), .TMO_W(T), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .value(value), .arm_valid(arm_valid),
      .arm_ready(rdy_s), .arm_mode(arm_mode), .arm_lo(arm_lo), .arm_hi(arm_hi),
      .arm_tmo(arm_tmo), .cancel(cancel), .busy(busy_s), .hit(hit_s),
      .timeout(tmo_s), .hit_value(hv_s));

   cond_wait_unit #(.WIDTH(W), .NCH(N), .TMO_W(T), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .value(value), .arm_valid(arm_valid),
      .arm_ready(rdy_u), .arm_mode(arm_mode), .arm_lo(arm_lo), .arm_hi(arm_hi),
      .arm_tmo(arm_tmo), .cancel(cancel), .busy(busy_u), .hit(hit_u),
      .timeout(tmo_u), .hit_value(hv_u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      arm_mode = '0;
      arm_lo   = '0;
      arm_hi   = '0;
      arm_tmo  = '0;
      for (int i = 0; i < N; i++) begin
         arm_mode[3*i +: 3] = a_mode[i];
         arm_lo[W*i +: W]   = a_lo[i];
         arm_hi[W*i +: W]   = a_hi[i];
         arm_tmo[T*i +: T]  = a_tmo[i];
      end
   end

   function automatic longint conv(logic [W-1:0] x, bit sgn);
      if (sgn) return longint'($signed(x));
      return longint'(x);
   endfunction

   function automatic bit cond_ok(logic [2:0] md, longint v, longint lo, longint hi);
      case (md)
         3'd0: return v == lo;
         3'd1: return v != lo;
         3'd2: return v < lo;
         3'd3: return v <= lo;
         3'd4: return v > lo;
         3'd5: return v >= lo;
         3'd6: return (lo < v) && (v < hi);
         default: return (lo <= v) && (v <= hi);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < N; c++) begin
            m_armed[k][c] = 0; m_mode[k][c] = '0; m_lo[k][c] = 0; m_hi[k][c] = 0;
            m_left[k][c] = 0; e_hit[k][c] = 0; e_tmo[k][c] = 0; e_hv[k][c] = '0;
         end
   endtask

   // One sampling edge: remaining budget counts failing samples down to zero.
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         bit sgn = (k == 0);
         for (int c = 0; c < N; c++) begin
            e_hit[k][c] = 0;
            e_tmo[k][c] = 0;
            if (!m_armed[k][c]) begin
               if (arm_valid[c]) begin
                  m_armed[k][c] = 1;
                  m_mode[k][c]  = a_mode[c];
                  m_lo[k][c]    = conv(a_lo[c], sgn);
                  m_hi[k][c]    = conv(a_hi[c], sgn);
                  m_left[k][c]  = int'(a_tmo[c]);
               end
            end else if (cancel[c]) begin
               m_armed[k][c] = 0;
            end else if (cond_ok(m_mode[k][c], conv(value, sgn), m_lo[k][c], m_hi[k][c])) begin
               m_armed[k][c] = 0;
               e_hit[k][c]   = 1;
               e_hv[k][c]    = value;
            end else if (m_left[k][c] > 0) begin
               m_left[k][c]--;
               if (m_left[k][c] == 0) begin
                  m_armed[k][c] = 0;
                  e_tmo[k][c]   = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [N-1:0]   er, eb, eh, et;
         logic [W*N-1:0] ev;
         er = '0; eb = '0; eh = '0; et = '0; ev = '0;
         for (int c = 0; c < N; c++) begin
            er[c] = !m_armed[k][c];
            eb[c] = m_armed[k][c];
            eh[c] = e_hit[k][c];
            et[c] = e_tmo[k][c];
            ev[W*c +: W] = e_hv[k][c];
         end
         if (k == 0) begin
            chk("s.arm_ready", 128'(rdy_s), 128'(er));
            chk("s.busy", 128'(busy_s), 128'(eb));
            chk("s.hit", 128'(hit_s), 128'(eh));
            chk("s.timeout", 128'(tmo_s), 128'(et));
            chk("s.hit_value", 128'(hv_s), 128'(ev));
         end else begin
            chk("u.arm_ready", 128'(rdy_u), 128'(er));
            chk("u.busy", 128'(busy_u), 128'(eb));
            chk("u.hit", 128'(hit_u), 128'(eh));
            chk("u.timeout", 128'(tmo_u), 128'(et));
            chk("u.hit_value", 128'(hv_u), 128'(ev));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic set_arm(int c, logic [2:0] md, logic [W-1:0] lo, logic [W-1:0] hi, logic [T-1:0] tmo);
      a_mode[c] = md; a_lo[c] = lo; a_hi[c] = hi; a_tmo[c] = tmo;
      arm_valid[c] = 1'b1;
   endtask

   task automatic check_reset_lit(string nm);
      chk({nm, ".ready"}, 128'(rdy_s), 128'(4'hF));
      chk({nm, ".busy"}, 128'(busy_s), 128'(0));
      chk({nm, ".hit"}, 128'({hit_s, hit_u}), 128'(0));
      chk({nm, ".tmo"}, 128'({tmo_s, tmo_u}), 128'(0));
      chk({nm, ".hv"}, 128'(hv_s), 128'(0));
   endtask

   logic [W-1:0] chain_hv[$];
   logic [W-1:0] seq[6];
   logic [2:0]   cm[4];
   logic [W-1:0] clo[4];
   logic [W-1:0] chi[4];

   initial begin
      rst_n = 1'b0; value = '0; arm_valid = '0; cancel = '0;
      for (int c = 0; c < N; c++) begin
         a_mode[c] = '0; a_lo[c] = '0; a_hi[c] = '0; a_tmo[c] = '0;
      end
      model_reset();
      #1;
      check_reset_lit("reset");
      #20 rst_n = 1'b1;
      step();

      // 1: sequential wait chain on ch0
      seq = '{0, 1, 2, 0, 2, 2};
      cm  = '{3'd0, 3'd2, 3'd0, 3'd6};
      clo = '{2, 2, 0, 1};
      chi = '{0, 0, 0, 3};
      begin
         int idx = 0;
         for (int cyc = 0; cyc < 24; cyc++) begin
            value = seq[cyc/4];
            arm_valid[0] = 1'b0;
            if (idx < 4 && !m_armed[0][0]) set_arm(0, cm[idx], clo[idx], chi[idx], '0);
            step();
            if (arm_valid[0]) idx++;
            if (hit_s[0]) chain_hv.push_back(hv_s[W-1:0]);
            chk("chain.no_tmo", 128'(tmo_s[0]), 128'(0));
         end
         arm_valid = '0;
      end
      chk("chain.count", 128'(chain_hv.size()), 128'(4));
      if (chain_hv.size() == 4) begin
         chk("chain.hv0", 128'(chain_hv[0]), 128'(2));
         chk("chain.hv1", 128'(chain_hv[1]), 128'(0));
         chk("chain.hv2", 128'(chain_hv[2]), 128'(0));
         chk("chain.hv3", 128'(chain_hv[3]), 128'(2));
      end

      // 2: immediate fire on ch1
      value = 5;
      set_arm(1, 3'd5, 5, 0, '0);
      step();
      arm_valid = '0;
      chk("imm.busy", 128'(busy_s[1]), 128'(1));
      chk("imm.nohit", 128'(hit_s[1]), 128'(0));
      step();
      chk("imm.hit", 128'(hit_s[1]), 128'(1));
      chk("imm.hv", 128'(hv_s[W*1 +: W]), 128'(5));
      chk("imm.busy_low", 128'(busy_s[1]), 128'(0));
      chk("imm.ready", 128'(rdy_s[1]), 128'(1));

      // 3: timeout on ch2, then hit beats timeout on the last sample
      value = 0;
      set_arm(2, 3'd0, 7, 0, 3);
      step();
      arm_valid = '0;
      step(); step();
      chk("tmo.s2", 128'({tmo_s[2], busy_s[2]}), 128'(2'b01));
      step();
      chk("tmo.s3", 128'({tmo_s[2], hit_s[2], busy_s[2]}), 128'(3'b100));
      step();
      set_arm(2, 3'd0, 7, 0, 3);
      step();
      arm_valid = '0;
      step(); step();
      value = 7;
      step();
      chk("tmo.hitwins", 128'({tmo_s[2], hit_s[2]}), 128'(2'b01));
      chk("tmo.hv", 128'(hv_s[W*2 +: W]), 128'(7));

      // 4: cancel vs hit, cancel while idle with arm
      value = 0;
      set_arm(3, 3'd0, 9, 0, '0);
      step();
      arm_valid = '0;
      step();
      value = 9; cancel[3] = 1'b1;
      step();
      chk("cancel.nohit", 128'(hit_s[3]), 128'(0));
      chk("cancel.ready", 128'(rdy_s[3]), 128'(1));
      chk("cancel.hv", 128'(hv_s[W*3 +: W]), 128'(0));
      set_arm(3, 3'd0, 1, 0, '0);
      step();
      arm_valid = '0;
      chk("cancel.idle_arm", 128'(busy_s[3]), 128'(1));
      step();
      cancel = '0;

      // 5: parallel channels
      value = 0;
      set_arm(0, 3'd4, 10, 0, '0);
      set_arm(1, 3'd2, 32'hFFFF_FFFF, 0, '0);
      set_arm(2, 3'd7, 3, 3, '0);
      set_arm(3, 3'd1, 0, 0, '0);
      step();
      arm_valid = '0;
      value = 32'hFFFF_FFFB;
      step();
      chk("par.m5.s", 128'(hit_s), 128'(4'b1010));
      chk("par.m5.u", 128'(hit_u), 128'(4'b1011));
      value = 3;
      step();
      chk("par.3.s", 128'(hit_s), 128'(4'b0100));
      value = 11;
      step();
      chk("par.11.s", 128'(hit_s), 128'(4'b0001));
      step();

      // 6: reset mid-wait
      value = 0;
      for (int c = 0; c < N; c++) set_arm(c, 3'd0, 123, 0, '0);
      step();
      arm_valid = '0;
      step();
      chk("mid.busy", 128'(busy_s), 128'(4'hF));
      rst_n = 1'b0;
      #1;
      check_reset_lit("midrst");
      model_reset();
      #2 rst_n = 1'b1;
      set_arm(0, 3'd0, 0, 0, '0);
      step();
      arm_valid = '0;
      step();
      chk("rearm.hit", 128'(hit_s[0]), 128'(1));

      // randomized traffic
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 3) == 0) value = $urandom;
         else value = W'($urandom_range(0, 16)) - W'(8);
         for (int c = 0; c < N; c++) begin
            logic [W-1:0] lo;
            lo = W'($urandom_range(0, 12)) - W'(6);
            a_mode[c]    = 3'($urandom_range(0, 7));
            a_lo[c]      = lo;
            a_hi[c]      = lo + W'($urandom_range(0, 8)) - W'(2);
            a_tmo[c]     = T'($urandom_range(0, 6));
            arm_valid[c] = ($urandom_range(0, 1) == 1);
            cancel[c]    = ($urandom_range(0, 15) == 0);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
